// File: rtl/dsopenhpsdr1_pkg.sv
// Shared OpenHPSDR protocol-1 framing constants, parser states and the C&C
// word decoder, used by the downstream parser and the upstream packer alike.
package dsopenhpsdr1_pkg;

  localparam logic [7:0] MET_PRE0       = 8'hEF;
  localparam logic [7:0] MET_PRE1       = 8'hFE;
  localparam logic [7:0] MET_TYPE_DATA  = 8'h01;
  localparam logic [7:0] MET_TYPE_DISC  = 8'h02;
  localparam logic [7:0] MET_TYPE_START = 8'h04;
  localparam logic [7:0] MET_EP2        = 8'h02;
  localparam logic [7:0] MET_SYNC       = 8'h7F;

  localparam int HDR_BYTES   = 8;
  localparam int FRAME_BYTES = 512;
  localparam int SYNC_BYTES  = 3;
  localparam int CC_BYTES    = 5;
  localparam int GROUP_BYTES = 8;

  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE = 4'd0;
  localparam state_t ST_PRE  = 4'd1;
  localparam state_t ST_TYPE = 4'd2;
  localparam state_t ST_SEQ  = 4'd3;
  localparam state_t ST_SYNC = 4'd4;
  localparam state_t ST_CC   = 4'd5;
  localparam state_t ST_SAMP = 4'd6;
  localparam state_t ST_CMD  = 4'd7;
  localparam state_t ST_DROP = 4'd8;

  typedef struct packed {
    logic [5:0]  addr;
    logic        ptt;
    logic [31:0] data;
  } cc_word_t;

  // C0 bit 7 carries no meaning on the downstream side.
  function automatic cc_word_t cc_decode(input logic [6:0] c0, input logic [23:0] c1_c3,
                                         input logic [7:0] c4);
    cc_word_t w;
    w.addr = c0[6:1];
    w.ptt  = c0[0];
    w.data = {c1_c3, c4};
    return w;
  endfunction

endpackage

// File: rtl/dsopenhpsdr1.sv
// Downstream OpenHPSDR protocol-1 parser: classifies UDP payloads, drives the
// shared C&C command bus and emits TX I/Q and L/R audio sample words.
module dsopenhpsdr1
  import dsopenhpsdr1_pkg::*;
#(
  parameter int SEQ_CHECK         = 1,
  parameter int SAMPLES_PER_FRAME = 63
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        udp_rx_active,
  input  logic [7:0]  udp_rx_data,
  output logic        run,
  output logic        wide_spectrum,
  output logic        discovery,
  output logic [5:0]  cmd_addr,
  output logic [31:0] cmd_data,
  output logic        cmd_rqst,
  output logic        cmd_ptt,
  output logic [31:0] ds_iq,
  output logic [31:0] ds_audio,
  output logic        ds_tvalid,
  output logic        seq_err,
  output logic        sync_err
);

  localparam int GW = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;
  localparam logic [GW-1:0] GRP_LAST = GW'(SAMPLES_PER_FRAME - 1);

  state_t        state_q, state_d;
  logic [10:0]   byte_cnt_q, byte_cnt_d;
  logic [2:0]    fld_q, fld_d;
  logic [GW-1:0] grp_q, grp_d;
  logic          frm_q, frm_d;
  logic [55:0]   sr_q, sr_d;
  logic [31:0]   exp_q, exp_d;
  logic          first_q, first_d;
  logic          run_q, run_d, wide_q, wide_d, disc_q, disc_d;
  logic [5:0]    cmd_addr_q, cmd_addr_d;
  logic [31:0]   cmd_data_q, cmd_data_d;
  logic          cmd_rqst_q, cmd_rqst_d, cmd_ptt_q, cmd_ptt_d;
  logic [31:0]   iq_q, iq_d, audio_q, audio_d;
  logic          tvalid_q, tvalid_d, seq_err_q, seq_err_d, sync_err_q, sync_err_d;

  cc_word_t    cc_w;
  logic [31:0] seq_val;

  // The one shift register holds the sequence number, C0..C3 and sample bytes.
  assign cc_w    = cc_decode(sr_q[30:24], sr_q[23:0], udp_rx_data);
  assign seq_val = {sr_q[23:0], udp_rx_data};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    fld_d      = fld_q;
    grp_d      = grp_q;
    frm_d      = frm_q;
    sr_d       = sr_q;
    exp_d      = exp_q;
    first_d    = first_q;
    run_d      = run_q;
    wide_d     = wide_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    cmd_ptt_d  = cmd_ptt_q;
    iq_d       = iq_q;
    audio_d    = audio_q;
    disc_d     = 1'b0;
    cmd_rqst_d = 1'b0;
    tvalid_d   = 1'b0;
    seq_err_d  = 1'b0;
    sync_err_d = 1'b0;
    if (!udp_rx_active) begin
      state_d    = ST_IDLE;
      byte_cnt_d = '0;
      fld_d      = '0;
    end else begin
      if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 11'd1;
      sr_d = {sr_q[47:0], udp_rx_data};
      case (state_q)
        ST_IDLE: state_d = (udp_rx_data == MET_PRE0) ? ST_PRE : ST_DROP;
        ST_PRE:  state_d = (udp_rx_data == MET_PRE1) ? ST_TYPE : ST_DROP;
        ST_TYPE: begin
          if (byte_cnt_q == 11'd2) begin
            case (udp_rx_data)
              MET_TYPE_DATA:  state_d = ST_TYPE;
              MET_TYPE_START: state_d = ST_CMD;
              MET_TYPE_DISC: begin
                disc_d  = 1'b1;
                state_d = ST_DROP;
              end
              default:        state_d = ST_DROP;
            endcase
          end else begin
            state_d = (udp_rx_data == MET_EP2) ? ST_SEQ : ST_DROP;
          end
        end
        ST_CMD: begin
          run_d   = udp_rx_data[0];
          wide_d  = udp_rx_data[1];
          if (run_q && !udp_rx_data[0]) exp_d = '0;
          if (!run_q && udp_rx_data[0]) first_d = 1'b1;
          state_d = ST_DROP;
        end
        ST_SEQ: begin
          if (byte_cnt_q == 11'(HDR_BYTES - 1)) begin
            if (SEQ_CHECK != 0 && run_q && !first_q && seq_val != exp_q) seq_err_d = 1'b1;
            if (run_q) first_d = 1'b0;
            exp_d   = seq_val + 32'd1;
            frm_d   = 1'b0;
            grp_d   = '0;
            fld_d   = '0;
            state_d = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (udp_rx_data != MET_SYNC) begin
            sync_err_d = 1'b1;
            state_d    = ST_DROP;
          end else if (fld_q == 3'(SYNC_BYTES - 1)) begin
            fld_d   = '0;
            state_d = ST_CC;
          end else begin
            fld_d = fld_q + 3'd1;
          end
        end
        ST_CC: begin
          if (fld_q == 3'(CC_BYTES - 1)) begin
            cmd_addr_d = cc_w.addr;
            cmd_ptt_d  = cc_w.ptt;
            cmd_data_d = cc_w.data;
            cmd_rqst_d = 1'b1;
            fld_d      = '0;
            grp_d      = '0;
            state_d    = ST_SAMP;
          end else begin
            fld_d = fld_q + 3'd1;
          end
        end
        ST_SAMP: begin
          if (fld_q == 3'(GROUP_BYTES - 1)) begin
            audio_d  = sr_q[55:24];
            iq_d     = {sr_q[23:0], udp_rx_data};
            tvalid_d = 1'b1;
            fld_d    = '0;
            if (grp_q == GRP_LAST) begin
              grp_d   = '0;
              frm_d   = 1'b1;
              state_d = frm_q ? ST_DROP : ST_SYNC;
            end else begin
              grp_d = grp_q + 1'b1;
            end
          end else begin
            fld_d = fld_q + 3'd1;
          end
        end
        default: state_d = ST_DROP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      fld_q      <= '0;
      grp_q      <= '0;
      frm_q      <= 1'b0;
      sr_q       <= '0;
      exp_q      <= '0;
      first_q    <= 1'b0;
      run_q      <= 1'b0;
      wide_q     <= 1'b0;
      disc_q     <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
      cmd_rqst_q <= 1'b0;
      cmd_ptt_q  <= 1'b0;
      iq_q       <= '0;
      audio_q    <= '0;
      tvalid_q   <= 1'b0;
      seq_err_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      fld_q      <= fld_d;
      grp_q      <= grp_d;
      frm_q      <= frm_d;
      sr_q       <= sr_d;
      exp_q      <= exp_d;
      first_q    <= first_d;
      run_q      <= run_d;
      wide_q     <= wide_d;
      disc_q     <= disc_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
      cmd_rqst_q <= cmd_rqst_d;
      cmd_ptt_q  <= cmd_ptt_d;
      iq_q       <= iq_d;
      audio_q    <= audio_d;
      tvalid_q   <= tvalid_d;
      seq_err_q  <= seq_err_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign run           = run_q;
  assign wide_spectrum = wide_q;
  assign discovery     = disc_q;
  assign cmd_addr      = cmd_addr_q;
  assign cmd_data      = cmd_data_q;
  assign cmd_rqst      = cmd_rqst_q;
  assign cmd_ptt       = cmd_ptt_q;
  assign ds_iq         = iq_q;
  assign ds_audio      = audio_q;
  assign ds_tvalid     = tvalid_q;
  assign seq_err       = seq_err_q;
  assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_dsopenhpsdr1.sv
// Directed bench for the downstream protocol-1 parser: a position-based packet
// model predicts every output each cycle, plus literal spot checks per scenario.
module tb_dsopenhpsdr1;

  localparam int SEQ_CHECK = 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        udp_rx_active = 1'b0;
  logic [7:0]  udp_rx_data = 8'h00;
  logic        run, wide_spectrum, discovery, cmd_rqst, cmd_ptt, ds_tvalid, seq_err, sync_err;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_data, ds_iq, ds_audio;

  dsopenhpsdr1 #(.SEQ_CHECK(SEQ_CHECK), .SAMPLES_PER_FRAME(63)) dut (
    .clk(clk), .rstn(rstn), .udp_rx_active(udp_rx_active), .udp_rx_data(udp_rx_data),
    .run(run), .wide_spectrum(wide_spectrum), .discovery(discovery),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_rqst(cmd_rqst), .cmd_ptt(cmd_ptt),
    .ds_iq(ds_iq), .ds_audio(ds_audio), .ds_tvalid(ds_tvalid),
    .seq_err(seq_err), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_pkts = 0;
  int n_rqst, n_tvalid, n_seq, n_sync, n_disc;
  bit fst_seen;
  logic [31:0] fst_iq, fst_audio;

  // Model of what the outputs must be after each sampled byte.
  logic        exp_run = 0, exp_wide = 0, exp_disc = 0, exp_rqst = 0, exp_ptt = 0;
  logic        exp_tvalid = 0, exp_seq = 0, exp_sync = 0;
  logic [5:0]  exp_addr = '0;
  logic [31:0] exp_data = '0, exp_iq = '0, exp_audio = '0;
  logic [31:0] m_expseq = '0;
  logic        m_first = 1'b0;

  logic [7:0] pkt [0:1039];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("run", 32'(run), 32'(exp_run));
    chk("wide_spectrum", 32'(wide_spectrum), 32'(exp_wide));
    chk("discovery", 32'(discovery), 32'(exp_disc));
    chk("cmd_addr", 32'(cmd_addr), 32'(exp_addr));
    chk("cmd_data", cmd_data, exp_data);
    chk("cmd_rqst", 32'(cmd_rqst), 32'(exp_rqst));
    chk("cmd_ptt", 32'(cmd_ptt), 32'(exp_ptt));
    chk("ds_iq", ds_iq, exp_iq);
    chk("ds_audio", ds_audio, exp_audio);
    chk("ds_tvalid", 32'(ds_tvalid), 32'(exp_tvalid));
    chk("seq_err", 32'(seq_err), 32'(exp_seq));
    chk("sync_err", 32'(sync_err), 32'(exp_sync));
    if (cmd_rqst)  n_rqst++;
    if (ds_tvalid) n_tvalid++;
    if (seq_err)   n_seq++;
    if (sync_err)  n_sync++;
    if (discovery) n_disc++;
    if (ds_tvalid && !fst_seen) begin
      fst_seen  = 1'b1;
      fst_iq    = ds_iq;
      fst_audio = ds_audio;
    end
  end

  task automatic zero_counts();
    n_rqst = 0; n_tvalid = 0; n_seq = 0; n_sync = 0; n_disc = 0; fst_seen = 1'b0;
  endtask

  task automatic clear_pulses();
    exp_disc = 0; exp_rqst = 0; exp_tvalid = 0; exp_seq = 0; exp_sync = 0;
  endtask

  task automatic build_start(input logic [7:0] b3);
    pkt[0] = 8'hEF; pkt[1] = 8'hFE; pkt[2] = 8'h04; pkt[3] = b3;
  endtask

  task automatic build_disc();
    pkt[0] = 8'hEF; pkt[1] = 8'hFE; pkt[2] = 8'h02;
    for (int p = 3; p < 63; p++) pkt[p] = 8'(p);
  endtask

  task automatic build_ep2(input logic [31:0] seq, input logic [7:0] c0,
                           input logic [31:0] cd, input int bad_pos);
    int base;
    pkt[0] = 8'hEF; pkt[1] = 8'hFE; pkt[2] = 8'h01; pkt[3] = 8'h02;
    pkt[4] = seq[31:24]; pkt[5] = seq[23:16]; pkt[6] = seq[15:8]; pkt[7] = seq[7:0];
    for (int f = 0; f < 2; f++) begin
      base = 8 + 512 * f;
      for (int j = 0; j < 3; j++) pkt[base + j] = 8'h7F;
      pkt[base + 3] = c0;         pkt[base + 4] = cd[31:24];
      pkt[base + 5] = cd[23:16];  pkt[base + 6] = cd[15:8];
      pkt[base + 7] = cd[7:0];
      for (int g = 0; g < 63; g++)
        for (int j = 0; j < 8; j++)
          pkt[base + 8 + 8 * g + j] = 8'((f * 64 + g) * 8 + j) ^ 8'h5A;
    end
    pkt[16] = 8'h00; pkt[17] = 8'h01; pkt[18] = 8'h00; pkt[19] = 8'h02;
    pkt[20] = 8'h7F; pkt[21] = 8'hFF; pkt[22] = 8'h80; pkt[23] = 8'h00;
    for (int p = 1032; p < 1040; p++) pkt[p] = 8'hA5;
    if (bad_pos >= 0) pkt[bad_pos] = 8'h7E;
  endtask

  // Streams nsend bytes; outputs predicted from byte positions within the packet.
  task automatic send_pkt(input int nsend, input int rst_at);
    bit hdr, is_ep2, did_rst;
    int limit, sync_pos, off, p;
    logic [31:0] val;
    logic [7:0] c0;
    hdr    = (pkt[0] == 8'hEF) && (pkt[1] == 8'hFE);
    is_ep2 = hdr && (pkt[2] == 8'h01) && (pkt[3] == 8'h02);
    limit = 1032;
    sync_pos = -1;
    for (int f = 0; f < 2; f++)
      for (int j = 0; j < 3; j++) begin
        p = 8 + 512 * f + j;
        if (sync_pos < 0 && pkt[p] != 8'h7F) begin
          sync_pos = p;
          limit = p + 1;
        end
      end
    n_pkts++;
    $display("pkt %0d: %0d bytes, type %02h", n_pkts, nsend, pkt[2]);
    did_rst = 1'b0;
    @(posedge clk); #1;
    clear_pulses();
    udp_rx_active = 1'b1;
    udp_rx_data = pkt[0];
    for (int k = 0; k < nsend && !did_rst; k++) begin
      @(posedge clk); #1;
      clear_pulses();
      if (k == rst_at) begin
        rstn = 1'b0;
        udp_rx_active = 1'b0;
        udp_rx_data = 8'h00;
        exp_run = 0; exp_wide = 0; exp_addr = '0; exp_data = '0; exp_ptt = 0;
        exp_iq = '0; exp_audio = '0; m_expseq = '0; m_first = 1'b0;
        did_rst = 1'b1;
        #1;
        chk("rst_run", 32'(run), 32'h0);
        chk("rst_cmd_data", cmd_data, 32'h0);
        chk("rst_ds_audio", ds_audio, 32'h0);
      end else begin
        if (hdr && k == 2 && pkt[2] == 8'h02) exp_disc = 1'b1;
        if (hdr && k == 3 && pkt[2] == 8'h04) begin
          if (exp_run && !pkt[3][0]) m_expseq = '0;
          if (!exp_run && pkt[3][0]) m_first = 1'b1;
          exp_run  = pkt[3][0];
          exp_wide = pkt[3][1];
        end
        if (is_ep2 && k == 7) begin
          val = {pkt[4], pkt[5], pkt[6], pkt[7]};
          if (SEQ_CHECK != 0 && exp_run && !m_first && val != m_expseq) exp_seq = 1'b1;
          m_expseq = val + 32'd1;
          if (exp_run) m_first = 1'b0;
        end
        if (is_ep2 && k == sync_pos) exp_sync = 1'b1;
        if (is_ep2 && k >= 8 && k < limit) begin
          off = (k - 8) % 512;
          if (off == 7) begin
            c0 = pkt[k - 4];
            exp_addr = c0[6:1];
            exp_ptt  = c0[0];
            exp_data = {pkt[k - 3], pkt[k - 2], pkt[k - 1], pkt[k]};
            exp_rqst = 1'b1;
          end else if (off >= 15 && (off - 8) % 8 == 7) begin
            exp_audio  = {pkt[k - 7], pkt[k - 6], pkt[k - 5], pkt[k - 4]};
            exp_iq     = {pkt[k - 3], pkt[k - 2], pkt[k - 1], pkt[k]};
            exp_tvalid = 1'b1;
          end
        end
        if (k + 1 < nsend) udp_rx_data = pkt[k + 1];
        else begin
          udp_rx_active = 1'b0;
          udp_rx_data = 8'h00;
        end
      end
    end
    repeat (2) begin
      @(posedge clk); #1;
      clear_pulses();
    end
    if (did_rst) rstn = 1'b1;
  endtask

  initial begin
    zero_counts();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_addr", 32'(cmd_addr), 32'h0);
    chk("reset_run", 32'(run), 32'h0);
    rstn = 1'b1;

    // Start / stop commands
    build_start(8'h03); send_pkt(4, -1);
    chk("t1_run_on", 32'(run), 32'h1);
    chk("t1_wide_on", 32'(wide_spectrum), 32'h1);
    build_start(8'h00); send_pkt(4, -1);
    chk("t1_run_off", 32'(run), 32'h0);

    // Full EP2 packet while stopped
    zero_counts();
    build_ep2(32'd0, 8'h13, 32'h12345678, -1); send_pkt(1032, -1);
    chk("t2_rqst_count", 32'(n_rqst), 32'd2);
    chk("t2_tvalid_count", 32'(n_tvalid), 32'd126);
    chk("t2_cmd_addr", 32'(cmd_addr), 32'h09);
    chk("t2_cmd_ptt", 32'(cmd_ptt), 32'h1);
    chk("t2_cmd_data", cmd_data, 32'h12345678);
    chk("t2_first_audio", fst_audio, 32'h00010002);
    chk("t2_first_iq", fst_iq, 32'h7FFF8000);

    // Sequence continuity
    zero_counts();
    build_start(8'h01); send_pkt(4, -1);
    build_ep2(32'd5, 8'h02, 32'hA1B2C3D4, -1); send_pkt(16, -1);
    build_ep2(32'd7, 8'h02, 32'hA1B2C3D4, -1); send_pkt(16, -1);
    chk("t3_seq_gap", 32'(n_seq), 32'd1);
    build_ep2(32'd8, 8'h02, 32'hA1B2C3D4, -1); send_pkt(16, -1);
    build_start(8'h00); send_pkt(4, -1);
    build_start(8'h01); send_pkt(4, -1);
    build_ep2(32'hFFFFFFFF, 8'h02, 32'hA1B2C3D4, -1); send_pkt(16, -1);
    build_ep2(32'd0, 8'h02, 32'hA1B2C3D4, -1); send_pkt(16, -1);
    chk("t3_seq_total", 32'(n_seq), 32'd1);

    // Bad second-frame sync, then a normal (over-long) packet
    zero_counts();
    build_ep2(32'd1, 8'h21, 32'h0BADF00D, 521); send_pkt(523, -1);
    chk("t4_sync_count", 32'(n_sync), 32'd1);
    chk("t4_rqst_count", 32'(n_rqst), 32'd1);
    chk("t4_tvalid_count", 32'(n_tvalid), 32'd63);
    zero_counts();
    build_ep2(32'd2, 8'h40, 32'hCAFEBABE, -1); send_pkt(1036, -1);
    chk("t4_next_rqst", 32'(n_rqst), 32'd2);
    chk("t4_next_tvalid", 32'(n_tvalid), 32'd126);
    chk("t4_next_seq", 32'(n_seq), 32'd0);

    // Truncated packets
    zero_counts();
    build_ep2(32'd3, 8'h05, 32'h01020304, -1); send_pkt(15, -1);
    chk("t5_cc_trunc", 32'(n_rqst), 32'd0);
    zero_counts();
    build_ep2(32'd4, 8'h07, 32'h05060708, -1); send_pkt(21, -1);
    chk("t5_grp_trunc", 32'(n_tvalid), 32'd0);
    zero_counts();
    build_ep2(32'd5, 8'h09, 32'h090A0B0C, -1); send_pkt(16, -1);
    chk("t5_recover", 32'(n_rqst), 32'd1);

    // Discovery, then reset mid-packet and recovery
    zero_counts();
    build_disc(); send_pkt(63, -1);
    chk("t6_disc_count", 32'(n_disc), 32'd1);
    build_ep2(32'd6, 8'h11, 32'h55AA55AA, -1); send_pkt(1032, 300);
    zero_counts();
    build_ep2(32'd0, 8'h31, 32'h87654321, -1); send_pkt(1032, -1);
    chk("t6_after_rst_rqst", 32'(n_rqst), 32'd2);
    chk("t6_after_rst_data", cmd_data, 32'h87654321);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
